// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (I) and load/store (D).
// Optional ack watchdog enabled by defining ARB_TIMEOUT_EN.
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT    = 64
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_done,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic            d_done,
    output logic [DW-1:0]   d_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    output logic [DW/8-1:0] m_wstrb,
    input  logic            m_ack,
    input  logic [DW-1:0]   m_rdata,
    output logic            busy,
    output logic            owner,
    output logic            err
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   wstrb_q, wstrb_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              grant_i, grant_d;
    logic              timed_out;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]     wdog_q, wdog_d;
    logic              err_q, err_d;

    assign timed_out = (state_q == BUSY) && !m_ack && (wdog_q == TW'(TIMEOUT - 1));
`else
    assign timed_out = 1'b0;
`endif

    // D wins ties unless I has already lost STARVE_MAX grants in a row.
    assign grant_i = i_req && (!d_req || (starve_q == SW'(STARVE_MAX)));
    assign grant_d = d_req && !grant_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_req || d_req) state_d = BUSY;
            BUSY:    if (m_ack || timed_out) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        owner_d  = owner_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rdata_d  = rdata_q;
        starve_d = starve_q;
`ifdef ARB_TIMEOUT_EN
        wdog_d   = wdog_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    owner_d  = 1'b0;
                    we_d     = 1'b0;
                    addr_d   = i_addr;
                    wdata_d  = '0;
                    wstrb_d  = '0;
                    starve_d = '0;
                end else if (grant_d) begin
                    owner_d  = 1'b1;
                    we_d     = d_we;
                    addr_d   = d_addr;
                    wdata_d  = d_wdata;
                    wstrb_d  = d_we ? d_wstrb : '0;
                    if (i_req && (starve_q != SW'(STARVE_MAX))) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
                if (!i_req) begin
                    starve_d = '0;
                end
`ifdef ARB_TIMEOUT_EN
                wdog_d = '0;
`endif
            end
            BUSY: begin
                if (m_ack) begin
                    rdata_d = m_rdata;
                end
`ifdef ARB_TIMEOUT_EN
                else if (timed_out) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + TW'(1);
                end
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            starve_q <= '0;
`ifdef ARB_TIMEOUT_EN
            wdog_q   <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rdata_q  <= rdata_d;
            starve_q <= starve_d;
`ifdef ARB_TIMEOUT_EN
            wdog_q   <= wdog_d;
            err_q    <= err_d;
`endif
        end
    end

    // Outputs depend only on registered state; the non-owner side always reads zero.
    always_comb begin
        m_req   = (state_q == BUSY);
        m_we    = we_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        m_wstrb = wstrb_q;
        busy    = (state_q != IDLE);
        owner   = owner_q;
        i_done  = (state_q == RESP) && !owner_q;
        d_done  = (state_q == RESP) && owner_q;
        i_rdata = i_done ? rdata_q : '0;
        d_rdata = (d_done && !we_q) ? rdata_q : '0;
`ifdef ARB_TIMEOUT_EN
        err     = err_q;
`else
        err     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the watchdog section runs only with ARB_TIMEOUT_EN.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_done;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        busy;
    logic        owner;
    logic        err;

    int compared   = 0;
    int mismatched = 0;

    mem_arbiter dut (
        .clk     (clk),
        .reset   (reset),
        .i_req   (i_req),
        .i_addr  (i_addr),
        .i_done  (i_done),
        .i_rdata (i_rdata),
        .d_req   (d_req),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_wdata (d_wdata),
        .d_wstrb (d_wstrb),
        .d_done  (d_done),
        .d_rdata (d_rdata),
        .m_req   (m_req),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_ack   (m_ack),
        .m_rdata (m_rdata),
        .busy    (busy),
        .owner   (owner),
        .err     (err)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle just after it, so checks see the new register values.
    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dreq, input logic dwe, input logic [31:0] daddr,
                                 input logic [31:0] dwdata, input logic [3:0] dwstrb);
        i_req   = ireq;
        i_addr  = iaddr;
        d_req   = dreq;
        d_we    = dwe;
        d_addr  = daddr;
        d_wdata = dwdata;
        d_wstrb = dwstrb;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: observed=hang expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        reset   = 1'b1;
        m_ack   = 1'b0;
        m_rdata = '0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        stepClock();
        stepClock();
        reset = 1'b0;

        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_m_req", {31'b0, m_req}, 32'd0);
        checkOutput("rst_i_done", {31'b0, i_done}, 32'd0);
        checkOutput("rst_d_done", {31'b0, d_done}, 32'd0);
        checkOutput("rst_m_addr", m_addr, 32'd0);
        checkOutput("rst_owner", {31'b0, owner}, 32'd0);
        checkOutput("rst_err", {31'b0, err}, 32'd0);

        // Single I read with zero-wait memory.
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, '0, '0, '0);
        stepClock();
        checkOutput("i1_m_req", {31'b0, m_req}, 32'd1);
        checkOutput("i1_m_addr", m_addr, 32'h10);
        checkOutput("i1_m_we", {31'b0, m_we}, 32'd0);
        checkOutput("i1_owner", {31'b0, owner}, 32'd0);
        m_ack = 1'b1;
        m_rdata = 32'h00000013;
        stepClock();
        m_ack = 1'b0;
        checkOutput("i1_m_req_drop", {31'b0, m_req}, 32'd0);
        checkOutput("i1_done", {31'b0, i_done}, 32'd1);
        checkOutput("i1_rdata", i_rdata, 32'h00000013);
        checkOutput("i1_d_done", {31'b0, d_done}, 32'd0);
        i_req = 1'b0;
        stepClock();
        checkOutput("i1_busy_after", {31'b0, busy}, 32'd0);
        checkOutput("i1_done_after", {31'b0, i_done}, 32'd0);

        // Simultaneous requests: D first, then I.
        applyStimulus(1'b1, 32'h80, 1'b1, 1'b0, 32'h200, '0, '0);
        stepClock();
        checkOutput("both_owner_d", {31'b0, owner}, 32'd1);
        checkOutput("both_m_addr_d", m_addr, 32'h200);
        m_ack = 1'b1;
        m_rdata = 32'hCAFE0001;
        stepClock();
        m_ack = 1'b0;
        checkOutput("both_d_done", {31'b0, d_done}, 32'd1);
        checkOutput("both_d_rdata", d_rdata, 32'hCAFE0001);
        checkOutput("both_i_rdata_zero", i_rdata, 32'd0);
        d_req = 1'b0;
        stepClock();
        stepClock();
        checkOutput("both_owner_i", {31'b0, owner}, 32'd0);
        checkOutput("both_m_addr_i", m_addr, 32'h80);
        m_ack = 1'b1;
        m_rdata = 32'h00001234;
        stepClock();
        m_ack = 1'b0;
        checkOutput("both_i_done", {31'b0, i_done}, 32'd1);
        checkOutput("both_i_rdata", i_rdata, 32'h00001234);
        i_req = 1'b0;
        stepClock();

        // Starvation: two rounds of D,D,D,D,I prove the counter clears after the I grant.
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'h300, '0, '0);
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < 5; k++) begin
                stepClock();
                checkOutput($sformatf("starve_owner_r%0d_g%0d", round, k), {31'b0, owner},
                            (k < 4) ? 32'd1 : 32'd0);
                checkOutput($sformatf("starve_addr_r%0d_g%0d", round, k), m_addr,
                            (k < 4) ? 32'h300 : 32'h100);
                m_ack = 1'b1;
                m_rdata = 32'h1000 + k;
                stepClock();
                m_ack = 1'b0;
                stepClock();
            end
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
        stepClock();

        // D write, memory acks after 3 wait cycles; payload must stay stable.
        applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 4'b0011);
        stepClock();
        for (int w = 0; w < 4; w++) begin
            checkOutput($sformatf("wr_m_req_%0d", w), {31'b0, m_req}, 32'd1);
            checkOutput($sformatf("wr_m_we_%0d", w), {31'b0, m_we}, 32'd1);
            checkOutput($sformatf("wr_m_wstrb_%0d", w), {28'b0, m_wstrb}, 32'h3);
            checkOutput($sformatf("wr_m_wdata_%0d", w), m_wdata, 32'hDEADBEEF);
            checkOutput($sformatf("wr_m_addr_%0d", w), m_addr, 32'h40);
            if (w == 3) begin
                m_ack = 1'b1;
                m_rdata = 32'hFFFFFFFF;
            end
            stepClock();
        end
        m_ack = 1'b0;
        checkOutput("wr_d_done", {31'b0, d_done}, 32'd1);
        checkOutput("wr_d_rdata", d_rdata, 32'd0);
        d_req = 1'b0;
        stepClock();
        checkOutput("wr_d_done_once", {31'b0, d_done}, 32'd0);
        checkOutput("wr_busy_after", {31'b0, busy}, 32'd0);

        // Reset during BUSY followed by a stray ack.
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, '0, '0, '0);
        stepClock();
        checkOutput("rb_m_req", {31'b0, m_req}, 32'd1);
        reset = 1'b1;
        stepClock();
        checkOutput("rb_busy", {31'b0, busy}, 32'd0);
        checkOutput("rb_m_req_low", {31'b0, m_req}, 32'd0);
        checkOutput("rb_i_done", {31'b0, i_done}, 32'd0);
        reset = 1'b0;
        i_req = 1'b0;
        m_ack = 1'b1;
        m_rdata = 32'h55;
        stepClock();
        m_ack = 1'b0;
        checkOutput("rb_stray_busy", {31'b0, busy}, 32'd0);
        checkOutput("rb_stray_i_done", {31'b0, i_done}, 32'd0);
        checkOutput("rb_stray_d_done", {31'b0, d_done}, 32'd0);
        checkOutput("rb_stray_i_rdata", i_rdata, 32'd0);
        stepClock();
        checkOutput("rb_idle_m_req", {31'b0, m_req}, 32'd0);
        checkOutput("rb_idle_i_done", {31'b0, i_done}, 32'd0);

`ifdef ARB_TIMEOUT_EN
        begin
            int n;
            applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, '0, '0, '0);
            stepClock();
            n = 0;
            while (m_req && n < 200) begin
                n++;
                stepClock();
            end
            checkOutput("to_busy_cycles", n, 32'd64);
            checkOutput("to_i_done", {31'b0, i_done}, 32'd1);
            checkOutput("to_i_rdata", i_rdata, 32'd0);
            checkOutput("to_err", {31'b0, err}, 32'd1);
            i_req = 1'b0;
            m_ack = 1'b1;
            m_rdata = 32'hBAD;
            stepClock();
            m_ack = 1'b0;
            checkOutput("to_late_ack_done", {31'b0, i_done}, 32'd0);
            checkOutput("to_err_sticky", {31'b0, err}, 32'd1);
            stepClock();
            checkOutput("to_err_sticky2", {31'b0, err}, 32'd1);
            reset = 1'b1;
            stepClock();
            reset = 1'b0;
            checkOutput("to_err_cleared", {31'b0, err}, 32'd0);
        end
`else
        checkOutput("err_tied_low", {31'b0, err}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch port (I) and load/store port (D).
- Sits between the pipeline and the memory model inside top.
- Arbitrates requests and issues exactly one memory transaction at a time.
- Registers and returns the response to the winning requester.
- Data requests have priority; a starvation counter guarantees fetch progress.

Parameters:
- AW, 32, address width
- DW, 32, data width (byte strobes = DW/8)
- STARVE_MAX, 4, consecutive D grants while I pending before I is forced to win
- TIMEOUT, 64, memory-ack watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  instruction read request; held with i_addr until i_done
- i_addr  in  AW  fetch address
- i_done  out  1  one-cycle pulse, i_rdata valid
- i_rdata  out  DW  fetched word
- d_req  in  1  data request; held with payload until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  AW  data address
- d_wdata  in  DW  write data
- d_wstrb  in  DW/8  byte enables (writes only)
- d_done  out  1  one-cycle pulse; d_rdata valid for reads
- d_rdata  out  DW  load data
- m_req  out  1  memory request; held until m_ack
- m_we  out  1  memory write enable
- m_addr  out  AW  memory address
- m_wdata  out  DW  memory write data
- m_wstrb  out  DW/8  memory byte enables
- m_ack  in  1  memory completion, single cycle; m_rdata valid same cycle
- m_rdata  in  DW  memory read data
- busy  out  1  state != IDLE
- owner  out  1  0 = I, 1 = D; valid while busy
- err  out  1  timeout error flag, sticky until reset (0 when feature compiled out)

Behaviour:
- Single clock; all state changes on posedge clk. reset is synchronous and active-high.
- Reset values: all outputs 0; state = IDLE; starve_cnt = 0; payload registers = 0.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant D, unless starve_cnt == STARVE_MAX, then grant I.
  - On grant: latch owner and payload (I grant forces we=0, wstrb=0); next state BUSY.
- BUSY:
  - m_req = 1, driven from the latched registers; payload is stable for the whole state.
  - On m_ack: capture m_rdata into a response register; next state RESP.
  - m_req drops in the cycle after m_ack.
- RESP:
  - Assert the owner's done for exactly one cycle; rdata is valid that cycle.
  - For a D write, d_rdata = 0.
  - Next state IDLE.
- Requesters must drop or replace req on the edge that samples done. IDLE therefore never sees a stale request.
- Timing: grant edge to m_req high = 1 cycle; m_ack to done = 1 cycle. Zero-wait memory gives 3 cycles per transaction: IDLE, BUSY, RESP.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each D grant while i_req = 1.
  - Clears on any I grant.
  - Clears when i_req = 0 in IDLE.
- m_ack outside BUSY is ignored, including a late ack arriving after reset.
- Requests arriving during BUSY/RESP wait; no queuing beyond the held req.
- Reset mid-transaction: return to IDLE next edge; m_req and done are low; no done is emitted for the aborted transaction.
- The unused done/rdata for the non-owner stays 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - A watchdog counter runs in BUSY, clearing on entry.
  - When it reaches TIMEOUT without m_ack, the arbiter goes to RESP and asserts the owner's done with rdata = 0.
  - err is set (sticky until reset), and m_req drops.
  - An ack arriving after the timeout is ignored.
- Without the macro: no counter, BUSY waits indefinitely, err is tied to 0.

Test Plan:
- Reset then single I read: i_addr=0x10, memory acks 0 cycles after m_req with 0x00000013 -> m_req high 1 cycle after grant; i_done one pulse 1 cycle after m_ack, i_rdata=0x00000013; busy low afterwards.
- Simultaneous i_req and d_req (D read 0x200) -> D granted first, m_addr=0x200; I granted on the next IDLE, m_addr=I address.
- Starvation: i_req held, d_req re-asserted continuously -> after 4 D grants, the 5th grant is I; starve_cnt returns to 0.
- D write: addr 0x40, wdata 0xDEADBEEF, wstrb 4'b0011, memory acks after 3 wait cycles -> m_we=1, m_wstrb=0011 stable across all BUSY cycles; d_done pulses once with d_rdata=0.
- Reset asserted during BUSY, then m_ack one cycle later -> state IDLE, no i_done/d_done pulse, m_req=0; the stray ack has no effect.
- (ARB_TIMEOUT_EN, TIMEOUT=64) memory never acks -> exactly 64 BUSY cycles, then the owner's done pulses with rdata=0 and err=1 until reset.
